// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_NUM_BITWIDTH_DEF = 5;
  localparam int unsigned NUM_REGS             = 2**REG_NUM_BITWIDTH_DEF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_t;

endpackage

// File: rtl/flush_timer.sv
// Holds if_flush for FLUSH_CYCLES cycles after a taken branch; a new branch
// during the window restarts it.
module flush_timer
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_branchTaken,
  output logic if_flush
);

  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(FLUSH_CYCLES - 1);

  flush_state_t  state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The branch cycle itself is covered combinationally, so FLUSH lasts
  // FLUSH_CYCLES-1 cycles and is skipped entirely when that is zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (ex_branchTaken && (RELOAD != '0)) begin
          state_n = ST_FLUSH;
          cnt_n   = RELOAD;
        end
      end
      ST_FLUSH: begin
        if (ex_branchTaken) begin
          cnt_n = RELOAD;
        end else if (cnt <= CW'(1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign if_flush = ex_branchTaken | (state == ST_FLUSH);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / scoreboard / structural hazard detection with pending-register
// tracking. Optional HAZARD_WB_BYPASS_EN lets a same-cycle writeback clear a
// source hazard.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_NUM_BITWIDTH = REG_NUM_BITWIDTH_DEF,
  parameter int unsigned MAX_OUTSTANDING  = 4,
  parameter int unsigned CNT_BITWIDTH     = 3,
  parameter int unsigned FLUSH_CYCLES     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          if_valid,
  input  logic [REG_NUM_BITWIDTH-1:0]   if_Rs1,
  input  logic [REG_NUM_BITWIDTH-1:0]   if_Rs2,
  input  logic                          id_memRead,
  input  logic [REG_NUM_BITWIDTH-1:0]   id_Rd,
  input  logic                          issue_long,
  input  logic [REG_NUM_BITWIDTH-1:0]   issue_Rd,
  input  logic                          wb_valid,
  input  logic [REG_NUM_BITWIDTH-1:0]   wb_Rd,
  input  logic                          ex_branchTaken,
  output logic                          stall,
  output logic                          PCWrite,
  output logic                          id_doNOP,
  output logic                          if_flush,
  output logic [2**REG_NUM_BITWIDTH-1:0] pending_mask,
  output logic [CNT_BITWIDTH-1:0]       pending_count
);

  localparam int unsigned NREG = 2**REG_NUM_BITWIDTH;
  localparam logic [CNT_BITWIDTH-1:0] CNT_MAX = CNT_BITWIDTH'(MAX_OUTSTANDING);

  logic            rs1_sb, rs2_sb, load_use, sb_hazard, struct_hazard;
  logic            accept, clear;
  logic [NREG-1:0] mask_n;
  logic [CNT_BITWIDTH-1:0] count_n;

  flush_timer #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush_timer (
    .clk            (clk),
    .rst            (rst),
    .ex_branchTaken (ex_branchTaken),
    .if_flush       (if_flush)
  );

`ifdef HAZARD_WB_BYPASS_EN
  // The register file forwards a same-cycle writeback to the read port.
  assign rs1_sb = pending_mask[if_Rs1] & ~(wb_valid && (wb_Rd == if_Rs1));
  assign rs2_sb = pending_mask[if_Rs2] & ~(wb_valid && (wb_Rd == if_Rs2));
`else
  assign rs1_sb = pending_mask[if_Rs1];
  assign rs2_sb = pending_mask[if_Rs2];
`endif

  assign load_use      = id_memRead && (id_Rd != '0) &&
                         ((id_Rd == if_Rs1) || (id_Rd == if_Rs2));
  assign sb_hazard     = rs1_sb | rs2_sb;
  assign struct_hazard = issue_long && (pending_mask[issue_Rd] || (pending_count == CNT_MAX));

  assign stall    = if_valid & (load_use | sb_hazard | struct_hazard) & ~if_flush;
  assign PCWrite  = ~stall;
  assign id_doNOP = stall;

  assign accept = if_valid & issue_long & ~stall & ~if_flush & (issue_Rd != '0);
  assign clear  = wb_valid & pending_mask[wb_Rd];

  // Set is applied after clear so a same-register pair leaves the bit set.
  always_comb begin
    mask_n  = pending_mask;
    count_n = pending_count;
    if (clear)  mask_n[wb_Rd]    = 1'b0;
    if (accept) mask_n[issue_Rd] = 1'b1;
    mask_n[0] = 1'b0;
    if (accept && !clear)      count_n = pending_count + CNT_BITWIDTH'(1);
    else if (clear && !accept) count_n = pending_count - CNT_BITWIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_mask  <= '0;
      pending_count <= '0;
    end else begin
      pending_mask  <= mask_n;
      pending_count <= count_n;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, id_memRead, issue_long, wb_valid, ex_branchTaken;
  logic [4:0]  if_Rs1, if_Rs2, id_Rd, issue_Rd, wb_Rd;
  logic        stall, PCWrite, id_doNOP, if_flush;
  logic [31:0] pending_mask;
  logic [2:0]  pending_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_Rs1(if_Rs1), .if_Rs2(if_Rs2),
    .id_memRead(id_memRead), .id_Rd(id_Rd), .issue_long(issue_long), .issue_Rd(issue_Rd),
    .wb_valid(wb_valid), .wb_Rd(wb_Rd), .ex_branchTaken(ex_branchTaken),
    .stall(stall), .PCWrite(PCWrite), .id_doNOP(id_doNOP), .if_flush(if_flush),
    .pending_mask(pending_mask), .pending_count(pending_count)
  );

  task automatic idle_inputs();
    if_valid = 0; if_Rs1 = 0; if_Rs2 = 0; id_memRead = 0; id_Rd = 0;
    issue_long = 0; issue_Rd = 0; wb_valid = 0; wb_Rd = 0; ex_branchTaken = 0;
  endtask

  // Advance to the next negedge (one posedge passes), settle, ready to check.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #2;
    tests++; if (pending_mask !== 32'h0) begin fails++; $display("FAIL reset_mask got %h exp 0", pending_mask); end
    tests++; if (pending_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", pending_count); end
    tests++; if ({stall, PCWrite, id_doNOP, if_flush} !== 4'b0100)
      begin fails++; $display("FAIL reset_ctrl got %b exp 0100", {stall, PCWrite, id_doNOP, if_flush}); end
    step(); rst = 0;
  endtask

  task automatic test_load_use();
    step(); idle_inputs();
    if_valid = 1; id_memRead = 1; id_Rd = 5; if_Rs2 = 5; #1;
    tests++; if ({stall, PCWrite, id_doNOP} !== 3'b101)
      begin fails++; $display("FAIL load_use_rs2 got %b exp 101", {stall, PCWrite, id_doNOP}); end
    if_Rs2 = 0; if_Rs1 = 5; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL load_use_rs1 got %b exp 1", stall); end
    id_Rd = 0; if_Rs1 = 0; #1;
    tests++; if ({stall, PCWrite} !== 2'b01) begin fails++; $display("FAIL load_use_x0 got %b exp 01", {stall, PCWrite}); end
    id_Rd = 5; if_Rs1 = 5; if_valid = 0; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL load_use_invalid got %b exp 0", stall); end
  endtask

  task automatic test_long_issue();
    step(); idle_inputs();
    if_valid = 1; issue_long = 1; issue_Rd = 7; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL issue7_accept got %b exp 0", stall); end
    step(); issue_long = 0; if_Rs1 = 7; #1;
    tests++; if ({stall, pending_count} !== {1'b1, 3'd1})
      begin fails++; $display("FAIL issue7_dep got stall=%b cnt=%0d exp 1/1", stall, pending_count); end
    tests++; if (pending_mask !== 32'h0000_0080) begin fails++; $display("FAIL issue7_mask got %h exp 80", pending_mask); end
    wb_valid = 1; wb_Rd = 7; #1;
`ifdef HAZARD_WB_BYPASS_EN
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL wb7_same_cycle got %b exp 0", stall); end
`else
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL wb7_same_cycle got %b exp 1", stall); end
`endif
    step(); wb_valid = 0; #1;
    tests++; if ({stall, pending_count} !== {1'b0, 3'd0})
      begin fails++; $display("FAIL wb7_after got stall=%b cnt=%0d exp 0/0", stall, pending_count); end
  endtask

  task automatic test_capacity();
    step(); idle_inputs();
    if_valid = 1; issue_long = 1;
    for (int r = 1; r <= 4; r++) begin
      issue_Rd = 5'(r); #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL cap_issue%0d got %b exp 0", r, stall); end
      step();
    end
    issue_Rd = 9; #1;
    tests++; if ({stall, pending_count, pending_mask} !== {1'b1, 3'd4, 32'h0000_001E})
      begin fails++; $display("FAIL cap_full got stall=%b cnt=%0d mask=%h exp 1/4/1e", stall, pending_count, pending_mask); end
    wb_valid = 1; wb_Rd = 2; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL cap_wb_cycle got %b exp 1", stall); end
    step(); wb_valid = 0; #1;
    tests++; if ({stall, pending_count} !== {1'b0, 3'd3})
      begin fails++; $display("FAIL cap_retry got stall=%b cnt=%0d exp 0/3", stall, pending_count); end
    step(); issue_long = 0; #1;
    tests++; if ({pending_count, pending_mask} !== {3'd4, 32'h0000_021A})
      begin fails++; $display("FAIL cap_accepted got cnt=%0d mask=%h exp 4/21a", pending_count, pending_mask); end
    wb_valid = 1;
    wb_Rd = 1; step(); wb_Rd = 3; step(); wb_Rd = 4; step(); wb_Rd = 9; step();
    wb_valid = 0; #1;
    tests++; if ({pending_count, pending_mask} !== {3'd0, 32'h0})
      begin fails++; $display("FAIL cap_drain got cnt=%0d mask=%h exp 0/0", pending_count, pending_mask); end
  endtask

  task automatic test_same_cycle();
    step(); idle_inputs();
    if_valid = 1; issue_long = 1; issue_Rd = 6;
    step(); #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL waw6 got %b exp 1", stall); end
    step(); #1;
    tests++; if ({pending_count, pending_mask} !== {3'd1, 32'h0000_0040})
      begin fails++; $display("FAIL waw6_held got cnt=%0d mask=%h exp 1/40", pending_count, pending_mask); end
    issue_Rd = 3; wb_valid = 1; wb_Rd = 6; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL set3_clr6_stall got %b exp 0", stall); end
    step(); #0;
    issue_long = 0; wb_valid = 0; #1;
    tests++; if ({pending_count, pending_mask} !== {3'd1, 32'h0000_0008})
      begin fails++; $display("FAIL set3_clr6 got cnt=%0d mask=%h exp 1/8", pending_count, pending_mask); end
    wb_valid = 1; wb_Rd = 5; issue_long = 1; issue_Rd = 5;
    step(); wb_valid = 1; wb_Rd = 0; issue_long = 0; #1;
    tests++; if ({pending_count, pending_mask} !== {3'd2, 32'h0000_0028})
      begin fails++; $display("FAIL wb_nonpending5 got cnt=%0d mask=%h exp 2/28", pending_count, pending_mask); end
    step(); #1;
    tests++; if ({pending_count, pending_mask} !== {3'd2, 32'h0000_0028})
      begin fails++; $display("FAIL wb_x0 got cnt=%0d mask=%h exp 2/28", pending_count, pending_mask); end
    issue_long = 1; issue_Rd = 0; wb_valid = 0; #1;
    step(); issue_long = 0; #1;
    tests++; if ({pending_count, pending_mask} !== {3'd2, 32'h0000_0028})
      begin fails++; $display("FAIL issue_x0 got cnt=%0d mask=%h exp 2/28", pending_count, pending_mask); end
    wb_valid = 1; wb_Rd = 3; step(); wb_Rd = 5; step(); wb_valid = 0; #1;
    tests++; if (pending_count !== 3'd0) begin fails++; $display("FAIL same_drain got %0d exp 0", pending_count); end
  endtask

  task automatic test_flush();
    step(); idle_inputs();
    if_valid = 1; id_memRead = 1; id_Rd = 5; if_Rs2 = 5;
    issue_long = 1; issue_Rd = 8; ex_branchTaken = 1; #1;
    tests++; if ({if_flush, stall, PCWrite} !== 3'b101)
      begin fails++; $display("FAIL flush_c0 got %b exp 101", {if_flush, stall, PCWrite}); end
    step(); ex_branchTaken = 0; #1;
    tests++; if ({if_flush, stall} !== 2'b10) begin fails++; $display("FAIL flush_c1 got %b exp 10", {if_flush, stall}); end
    step(); issue_long = 0; #1;
    tests++; if ({if_flush, stall, pending_mask} !== {2'b01, 32'h0})
      begin fails++; $display("FAIL flush_c2 got flush/stall=%b mask=%h exp 01/0", {if_flush, stall}, pending_mask); end
    idle_inputs(); ex_branchTaken = 1;
    step(); ex_branchTaken = 0;
    step(); ex_branchTaken = 1; #1;
    tests++; if (if_flush !== 1'b1) begin fails++; $display("FAIL flush2_c2 got %b exp 1", if_flush); end
    step(); ex_branchTaken = 0; #1;
    tests++; if (if_flush !== 1'b1) begin fails++; $display("FAIL flush2_c3 got %b exp 1", if_flush); end
    step(); #1;
    tests++; if (if_flush !== 1'b0) begin fails++; $display("FAIL flush2_c4 got %b exp 0", if_flush); end
  endtask

  task automatic test_reset_mid();
    step(); idle_inputs();
    if_valid = 1; issue_long = 1;
    issue_Rd = 10; step(); issue_Rd = 11; step(); issue_Rd = 12; step();
    idle_inputs(); ex_branchTaken = 1;
    step(); ex_branchTaken = 0; #1;
    tests++; if ({if_flush, pending_count} !== {1'b1, 3'd3})
      begin fails++; $display("FAIL pre_reset got flush=%b cnt=%0d exp 1/3", if_flush, pending_count); end
    #1 rst = 1; #1;
    tests++; if ({pending_mask, pending_count, if_flush} !== {32'h0, 3'd0, 1'b0})
      begin fails++; $display("FAIL async_reset got mask=%h cnt=%0d flush=%b exp 0/0/0", pending_mask, pending_count, if_flush); end
    step(); rst = 0; #1;
    tests++; if ({stall, PCWrite, if_flush} !== 3'b010)
      begin fails++; $display("FAIL post_reset got %b exp 010", {stall, PCWrite, if_flush}); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_long_issue();
    test_capacity();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
